// File: rtl/aes_key_pkg.sv
// Shared types and helpers for the AES key expansion engine: mode enum,
// per-mode constants, the forward S-box and GF(2^8) doubling.
package aes_key_pkg;

  typedef enum logic [1:0] {
    KL_128 = 2'd0,
    KL_192 = 2'd1,
    KL_256 = 2'd2,
    KL_BAD = 2'd3
  } key_len_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [3:0] nk_of(input key_len_e kl);
    case (kl)
      KL_128:  return 4'd4;
      KL_192:  return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input key_len_e kl);
    case (kl)
      KL_128:  return 4'd10;
      KL_192:  return 4'd12;
      default: return 4'd14;
    endcase
  endfunction

  function automatic logic [5:0] total_words_of(input key_len_e kl);
    case (kl)
      KL_128:  return 6'd44;
      KL_192:  return 6'd52;
      default: return 6'd60;
    endcase
  endfunction

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_schedule_gen_sbox_word.sv
// Combinational SubWord: forward S-box applied to each byte of a 32-bit word.
module aes_sbox_word
  import aes_key_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign word_o[8*b +: 8] = SBOX[word_i[8*b +: 8]];
  end

endmodule

// File: rtl/aes_key_schedule_gen.sv
// Iterative AES-128/192/256 key expansion, one schedule word per clock, with a
// round-key store read out four words at a time by round index.
//
// state | meaning
// IDLE  | no valid schedule, waiting for start
// GEN   | writing w[i] each cycle until w[T-1]
// DONE  | schedule valid, round_key readable, start re-expands
module aes_key_schedule_gen
  import aes_key_pkg::*;
#(
  parameter int MAX_NK      = 8,
  parameter int STORE_WORDS = 60
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          start,
  input  logic [1:0]                    key_len,
  input  logic [3:0][MAX_NK-1:0][7:0]   cipher_key,
  input  logic [3:0]                    key_sel,
  output logic                          busy,
  output logic                          key_rdy,
  output logic                          key_err,
  output logic [3:0][3:0][7:0]          round_key
);

  localparam logic [3:0] MAX_NK_W = 4'(MAX_NK);

  state_e                 state_q, state_d;
  key_len_e               kl_q, kl_d;
  logic [5:0]             i_q, i_d;
  logic [2:0]             j_q, j_d;
  logic [7:0]             rcon_q, rcon_d;
  logic                   key_rdy_q, key_rdy_d;
  logic                   key_err_q, key_err_d;
  logic [3:0][3:0][7:0]   rk_q, rk_d;
  logic [31:0]            store_q [STORE_WORDS];

  logic        load_en, gen_we, start_legal;
  logic [3:0]  nk_in, nk_q, nr_q;
  logic [5:0]  tw_q;
  logic [31:0] w_prev, w_back, sbox_in, sub_out, temp, gen_word;
  logic [5:0]  rd_idx  [4];
  logic [31:0] rd_word [4];

  assign nk_in       = nk_of(key_len_e'(key_len));
  assign start_legal = (key_len != 2'd3) && (nk_in <= MAX_NK_W);
  assign nk_q        = nk_of(kl_q);
  assign nr_q        = nr_of(kl_q);
  assign tw_q        = total_words_of(kl_q);

  // Temp path: one shared SubWord serves both the RotWord (j==0) and AES-256 (j==4) cases
  assign w_prev  = store_q[i_q - 6'd1];
  assign w_back  = store_q[i_q - {2'b00, nk_q}];
  assign sbox_in = (j_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  aes_sbox_word u_sbox (
    .word_i (sbox_in),
    .word_o (sub_out)
  );

  always_comb begin
    temp = w_prev;
    if (j_q == 3'd0)                          temp = sub_out ^ {rcon_q, 24'h0};
    else if (kl_q == KL_256 && j_q == 3'd4)   temp = sub_out;
  end

  assign gen_word = w_back ^ temp;

  always_comb begin
    state_d   = state_q;
    kl_d      = kl_q;
    i_d       = i_q;
    j_d       = j_q;
    rcon_d    = rcon_q;
    key_rdy_d = key_rdy_q;
    key_err_d = key_err_q;
    load_en   = 1'b0;
    gen_we    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          key_rdy_d = 1'b0;
          if (start_legal) begin
            kl_d      = key_len_e'(key_len);
            i_d       = {2'b00, nk_in};
            j_d       = 3'd0;
            rcon_d    = 8'h01;
            key_err_d = 1'b0;
            load_en   = 1'b1;
            state_d   = ST_GEN;
          end else begin
            key_err_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_GEN: begin
        gen_we = 1'b1;
        i_d    = i_q + 6'd1;
        j_d    = ({1'b0, j_q} == nk_q - 4'd1) ? 3'd0 : j_q + 3'd1;
        if (j_q == 3'd0) rcon_d = xtime(rcon_q);
        if (i_q == tw_q - 6'd1) begin
          state_d   = ST_DONE;
          key_rdy_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  for (genvar c = 0; c < 4; c++) begin : g_rd
    assign rd_idx[c]  = {key_sel, 2'b00} + 6'(c);
    assign rd_word[c] = store_q[rd_idx[c]];
  end

  always_comb begin
    rk_d = '0;
    if (key_rdy_q && key_sel <= nr_q) begin
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) begin
          rk_d[r][c] = rd_word[c][31-8*r -: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      kl_q      <= KL_128;
      i_q       <= '0;
      j_q       <= '0;
      rcon_q    <= 8'h01;
      key_rdy_q <= 1'b0;
      key_err_q <= 1'b0;
      rk_q      <= '0;
    end else begin
      state_q   <= state_d;
      kl_q      <= kl_d;
      i_q       <= i_d;
      j_q       <= j_d;
      rcon_q    <= rcon_d;
      key_rdy_q <= key_rdy_d;
      key_err_q <= key_err_d;
      rk_q      <= rk_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < STORE_WORDS; k++) store_q[k] <= '0;
    end else if (load_en) begin
      for (int k = 0; k < MAX_NK; k++) begin
        if (k < int'(nk_in))
          store_q[k] <= {cipher_key[0][k], cipher_key[1][k], cipher_key[2][k], cipher_key[3][k]};
      end
    end else if (gen_we) begin
      store_q[i_q] <= gen_word;
    end
  end

  assign busy      = (state_q == ST_GEN);
  assign key_rdy   = key_rdy_q;
  assign key_err   = key_err_q;
  assign round_key = rk_q;

endmodule

// File: tb/tb_aes_key_schedule_gen.sv
// Directed bench for the AES key expansion engine using the FIPS-197
// appendix A key vectors and handshake/bounds/reset scenarios.
module tb_aes_key_schedule_gen;

  logic                  clk = 1'b0;
  logic                  resetn;
  logic                  start;
  logic [1:0]            key_len;
  logic [3:0][7:0][7:0]  cipher_key;
  logic [3:0]            key_sel;
  logic                  busy, key_rdy, key_err;
  logic [3:0][3:0][7:0]  round_key;

  int passed = 0;
  int total  = 0;

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  always #5 clk = ~clk;

  aes_key_schedule_gen #(.MAX_NK(8), .STORE_WORDS(60)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .key_len    (key_len),
    .cipher_key (cipher_key),
    .key_sel    (key_sel),
    .busy       (busy),
    .key_rdy    (key_rdy),
    .key_err    (key_err),
    .round_key  (round_key)
  );

  // Word c of the key sits at bits [255-32c -: 32]; row 0 is the word MSB.
  function automatic logic [3:0][7:0][7:0] pack_key(input logic [255:0] k);
    logic [3:0][7:0][7:0] p;
    p = '0;
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 4; r++)
        p[r][c] = k[255-32*c-8*r -: 8];
    return p;
  endfunction

  function automatic logic [127:0] rk_words(input logic [3:0][3:0][7:0] rk);
    logic [127:0] w;
    w = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        w[127-32*c-8*r -: 8] = rk[r][c];
    return w;
  endfunction

  task automatic run_expand(input logic [1:0] kl, input logic [255:0] key, input int glitch_at,
                            output int cycles, output logic busy0, output logic rdy0);
    key_len    = kl;
    cipher_key = pack_key(key);
    start      = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    busy0  = busy;
    rdy0   = key_rdy;
    cycles = -1;
    for (int n = 1; n <= 100; n++) begin
      if (n == glitch_at) begin
        start      = 1'b1;
        key_len    = 2'd2;
        cipher_key = pack_key(KEY256);
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (key_rdy) begin
        cycles = n;
        break;
      end
    end
  endtask

  task automatic read_rk(input logic [3:0] sel, output logic [127:0] w);
    key_sel = sel;
    @(posedge clk); #1;
    w = rk_words(round_key);
  endtask

  task automatic test_reset;
    resetn = 1'b0; start = 1'b0; key_len = 2'd0; cipher_key = '0; key_sel = 4'd0;
    #12;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (key_rdy !== 1'b0) $display("FAIL reset_key_rdy: got %b expected 0", key_rdy); else passed++;
    total++; if (key_err !== 1'b0) $display("FAIL reset_key_err: got %b expected 0", key_err); else passed++;
    total++; if (round_key !== '0) $display("FAIL reset_round_key: got %h expected 0", round_key); else passed++;
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_aes128;
    int cyc; logic b0, r0; logic [127:0] w;
    run_expand(2'd0, KEY128, 0, cyc, b0, r0);
    total++; if (b0 !== 1'b1) $display("FAIL a128_busy_after_start: got %b expected 1", b0); else passed++;
    total++; if (r0 !== 1'b0) $display("FAIL a128_rdy_after_start: got %b expected 0", r0); else passed++;
    total++; if (cyc !== 40) $display("FAIL a128_latency: got %0d expected 40", cyc); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL a128_busy_done: got %b expected 0", busy); else passed++;
    read_rk(4'd0, w);
    total++; if (w !== 128'h2b7e151628aed2a6abf7158809cf4f3c) $display("FAIL a128_rk0: got %h expected 2b7e151628aed2a6abf7158809cf4f3c", w); else passed++;
    read_rk(4'd1, w);
    total++; if (w !== 128'ha0fafe1788542cb123a339392a6c7605) $display("FAIL a128_rk1: got %h expected a0fafe1788542cb123a339392a6c7605", w); else passed++;
    read_rk(4'd10, w);
    total++; if (w !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) $display("FAIL a128_rk10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", w); else passed++;
  endtask

  task automatic test_bounds;
    logic [127:0] w;
    for (int s = 11; s <= 15; s++) begin
      read_rk(4'(s), w);
      total++; if (w !== '0) $display("FAIL bounds_sel%0d: got %h expected 0", s, w); else passed++;
    end
    total++; if (key_rdy !== 1'b1) $display("FAIL bounds_key_rdy: got %b expected 1", key_rdy); else passed++;
  endtask

  task automatic test_start_during_gen;
    int cyc; logic b0, r0; logic [127:0] w;
    run_expand(2'd0, KEY128, 10, cyc, b0, r0);
    total++; if (cyc !== 40) $display("FAIL glitch_latency: got %0d expected 40", cyc); else passed++;
    read_rk(4'd1, w);
    total++; if (w !== 128'ha0fafe1788542cb123a339392a6c7605) $display("FAIL glitch_rk1: got %h expected a0fafe1788542cb123a339392a6c7605", w); else passed++;
    read_rk(4'd10, w);
    total++; if (w !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) $display("FAIL glitch_rk10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", w); else passed++;
    read_rk(4'd14, w);
    total++; if (w !== '0) $display("FAIL glitch_mode_kept: got %h expected 0", w); else passed++;
  endtask

  task automatic test_restart_in_done;
    int cyc; logic b0, r0; logic [127:0] w;
    run_expand(2'd2, KEY256, 0, cyc, b0, r0);
    total++; if (r0 !== 1'b0) $display("FAIL restart_rdy_dropped: got %b expected 0", r0); else passed++;
    total++; if (b0 !== 1'b1) $display("FAIL restart_busy: got %b expected 1", b0); else passed++;
    total++; if (cyc !== 52) $display("FAIL a256_latency: got %0d expected 52", cyc); else passed++;
    read_rk(4'd2, w);
    total++; if (w !== 128'h9ba354118e6925afa51a8b5f2067fcde) $display("FAIL a256_rk2: got %h expected 9ba354118e6925afa51a8b5f2067fcde", w); else passed++;
    read_rk(4'd3, w);
    total++; if (w !== 128'ha8b09c1a93d194cdbe49846eb75d5b9a) $display("FAIL a256_rk3: got %h expected a8b09c1a93d194cdbe49846eb75d5b9a", w); else passed++;
    read_rk(4'd14, w);
    total++; if (w !== 128'hfe4890d1e6188d0b046df344706c631e) $display("FAIL a256_rk14: got %h expected fe4890d1e6188d0b046df344706c631e", w); else passed++;
  endtask

  task automatic test_aes192;
    int cyc; logic b0, r0; logic [127:0] w;
    run_expand(2'd1, KEY192, 0, cyc, b0, r0);
    total++; if (cyc !== 46) $display("FAIL a192_latency: got %0d expected 46", cyc); else passed++;
    read_rk(4'd1, w);
    total++; if (w !== 128'h62f8ead2522c6b7bfe0c91f72402f5a5) $display("FAIL a192_rk1: got %h expected 62f8ead2522c6b7bfe0c91f72402f5a5", w); else passed++;
    read_rk(4'd12, w);
    total++; if (w !== 128'he98ba06f448c773c8ecc720401002202) $display("FAIL a192_rk12: got %h expected e98ba06f448c773c8ecc720401002202", w); else passed++;
    read_rk(4'd13, w);
    total++; if (w !== '0) $display("FAIL a192_rk13: got %h expected 0", w); else passed++;
  endtask

  task automatic test_illegal_len;
    int cyc; logic b0, r0; logic [127:0] w;
    key_len = 2'd3;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (key_err !== 1'b1) $display("FAIL illegal_key_err: got %b expected 1", key_err); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL illegal_busy: got %b expected 0", busy); else passed++;
    total++; if (key_rdy !== 1'b0) $display("FAIL illegal_key_rdy: got %b expected 0", key_rdy); else passed++;
    read_rk(4'd1, w);
    total++; if (w !== '0) $display("FAIL illegal_round_key: got %h expected 0", w); else passed++;
    total++; if (key_err !== 1'b1) $display("FAIL illegal_err_sticky: got %b expected 1", key_err); else passed++;
    run_expand(2'd0, KEY128, 0, cyc, b0, r0);
    total++; if (key_err !== 1'b0) $display("FAIL illegal_err_cleared: got %b expected 0", key_err); else passed++;
    total++; if (cyc !== 40) $display("FAIL illegal_recover_latency: got %0d expected 40", cyc); else passed++;
  endtask

  task automatic test_reset_mid_gen;
    int cyc; logic b0, r0; logic [127:0] w;
    key_len    = 2'd0;
    cipher_key = pack_key(KEY128);
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    total++; if (busy !== 1'b1) $display("FAIL midreset_busy_before: got %b expected 1", busy); else passed++;
    resetn = 1'b0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b expected 0", busy); else passed++;
    total++; if (key_rdy !== 1'b0) $display("FAIL midreset_key_rdy: got %b expected 0", key_rdy); else passed++;
    total++; if (key_err !== 1'b0) $display("FAIL midreset_key_err: got %b expected 0", key_err); else passed++;
    total++; if (round_key !== '0) $display("FAIL midreset_round_key: got %h expected 0", round_key); else passed++;
    repeat (2) @(posedge clk);
    @(negedge clk); resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0 || key_rdy !== 1'b0) $display("FAIL midreset_idle: got busy=%b rdy=%b expected 0 0", busy, key_rdy); else passed++;
    run_expand(2'd0, KEY128, 0, cyc, b0, r0);
    total++; if (cyc !== 40) $display("FAIL midreset_latency: got %0d expected 40", cyc); else passed++;
    read_rk(4'd1, w);
    total++; if (w !== 128'ha0fafe1788542cb123a339392a6c7605) $display("FAIL midreset_rk1: got %h expected a0fafe1788542cb123a339392a6c7605", w); else passed++;
    read_rk(4'd10, w);
    total++; if (w !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) $display("FAIL midreset_rk10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", w); else passed++;
  endtask

  initial begin
    test_reset();
    test_aes128();
    test_bounds();
    test_start_during_gen();
    test_restart_in_done();
    test_aes192();
    test_illegal_len();
    test_reset_mid_gen();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule_gen.md
# aes_key_schedule_gen

Parametrised, runtime-mode AES key expansion engine supporting AES-128, AES-192 and AES-256. It generates the full FIPS-197 word schedule iteratively at one 32-bit word per clock. The schedule is held in an internal round-key store. Any round key can then be read by index from the cipher datapath. It replaces the fixed 128-bit expander in the encryption core and feeds the AddRoundKey stage of both encrypt and decrypt paths.

## Interface
Parameters:
- `MAX_NK`, default 8: largest supported key length in 32-bit words. Legal values are 4, 6 or 8. It sizes `cipher_key` and the store.
- `STORE_WORDS`, default 60: round-key store depth, equal to 4*(Nr_max+1). It must match `MAX_NK` (44/52/60).

Ports:
- `clk`, in, 1: the single clock. All state updates on its rising edge.
- `resetn`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle request to expand `cipher_key` in mode `key_len`.
- `key_len`, in, 2: 0 = AES-128, 1 = AES-192, 2 = AES-256. Value 3 is illegal.
- `cipher_key`, in, `logic [7:0] [3:0][MAX_NK-1:0]`: byte `[r][c]` is row r of key column c. Column c is word w[c], with row 0 as the MSB.
- `key_sel`, in, 4: round-key index, 0..Nr.
- `busy`, out, 1: expansion in progress.
- `key_rdy`, out, 1: the full schedule for the last accepted key is valid.
- `key_err`, out, 1: sticky flag. Set when `start` arrives with `key_len`=3; cleared by the next legal `start`.
- `round_key`, out, `logic [7:0] [3:0][3:0]`: `[r][c]` is byte r of word w[4*key_sel+c].

## Operation
- Mode constants:
  - Nk = 4/6/8.
  - Nr = 10/12/14.
  - Total words T = 4*(Nr+1) = 44/52/60.
- FSM states are IDLE, GEN and DONE.
- **IDLE/DONE + `start` with a legal `key_len`:**
  - Latch `key_len`.
  - Write w[0..Nk-1] from `cipher_key` columns 0..Nk-1. Unused columns are ignored.
  - Set the word counter i=Nk, the phase counter j=0 and rcon=8'h01.
  - Clear `key_rdy`, set `busy`, go to GEN.
- **IDLE/DONE + `start` with `key_len`=3:**
  - Set `key_err`.
  - Stay in, or return to, IDLE.
  - `key_rdy` is cleared.
- **GEN, each cycle:**
  - temp = w[i-1].
  - If j==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, and rcon advances by xtime (8'h80 → 8'h1B).
  - Else if Nk==8 and j==4: temp = SubWord(temp).
  - Write w[i] = w[i-Nk] ^ temp.
  - Increment i. j increments modulo Nk; no divider is used.
- **End of GEN:** when w[T-1] is written, go to DONE, set `key_rdy` and clear `busy`.
- **`start` during GEN** is ignored. No queueing, no restart.
- **Read port:** `round_key` is registered every cycle.
  - It takes store words 4*`key_sel`..+3 when `key_rdy`=1 and `key_sel`≤Nr.
  - Otherwise it is all zeros.

## Timing
- Reset values:
  - State IDLE.
  - `busy`=0, `key_rdy`=0, `key_err`=0.
  - `round_key`=0.
  - Entire store = 0.
  - Counters = 0, rcon = 8'h01.
- Reset asserted mid-GEN aborts immediately. After release the block sits in IDLE and needs a new `start`.
- Start edge = edge 0.
  - `busy` is high after edge 0.
  - w[Nk+k] is written at edge k+1.
- `key_rdy` rises, and `busy` falls, after edge T-Nk: 40 for AES-128, 46 for AES-192, 52 for AES-256.
- `round_key` read latency is 1 cycle from a `key_sel` change. It is first valid the edge after `key_rdy` rises.
- `start` in DONE drops `key_rdy` at that edge. The previous schedule is overwritten progressively.

## Structure
- Package `aes_key_pkg` holds:
  - the `key_len_e` enum;
  - `nk_of()`, `nr_of()` and `total_words_of()` functions;
  - the 256-entry S-box constant;
  - the `xtime()` function.
- Sub-module `aes_sbox_word` is a combinational 4-byte SubWord, instantiated once on the temp path.

## Test plan
- **AES-128, FIPS-197 A.1:**
  - Stimulus: key 2b7e1516 28aed2a6 abf71588 09cf4f3c.
  - Required response: `key_rdy` 40 cycles after `start`; w[4]=a0fafe17; `key_sel`=10 gives w[43]=b6630ca6.
- **AES-192, A.2:**
  - Stimulus: key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b.
  - Required response: `key_rdy` after 46 cycles; w[6]=fe0c91f7; w[51]=01002202.
- **AES-256, A.3:**
  - Stimulus: key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4.
  - Required response: `key_rdy` after 52 cycles; w[8]=9ba35411; w[12] uses the j==4 SubWord path; w[59]=706c631e.
- **Handshake:**
  - `start` pulsed at GEN cycle 10 is ignored; the schedule matches A.1.
  - `start` in DONE with an AES-256 key clears `key_rdy` and produces the A.3 schedule.
- **Bounds:**
  - AES-128 with `key_sel`=11..15 → `round_key`=0.
  - `key_len`=3 → `key_err`=1, `busy`=0, `key_rdy`=0.
- **Reset mid-operation:**
  - `resetn` low at GEN cycle 20 → all outputs 0 asynchronously.
  - A fresh `start` after release reproduces the A.1 schedule.
